// File: rtl/adc_mux_ctrl.sv
// Multi-channel ADC controller: start/EOC/OE handshake, channel select, auto-scan, busy and channel tag.
// Optional sticky overrun flag built only when ADC_MUX_OVR_EN is defined.
module adc_mux_ctrl #(
  parameter int CH_NUM      = 4,
  parameter int ANA_W       = 32,
  parameter int DATA_W      = 12,
  parameter int CONV_CYCLES = 10,
  localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [CH_NUM*ANA_W-1:0]  anadata,
  input  logic                     start,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic                     scan_mode,
  input  logic                     OE,
  output logic                     EOC,
  output logic                     busy,
  output logic [DATA_W-1:0]        adc_data,
  output logic [CH_W-1:0]          adc_ch,
  output logic                     ovr
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CONVERT = 3'd2,
    S_DONE    = 3'd3,
    S_READ    = 3'd4
  } state_t;

  state_t state_reg, state_next;
  logic   eoc_reg, eoc_next;
  logic   busy_reg, busy_next;

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CH_W-1:0]   cur_ch_reg, cur_ch_next;
  logic              scan_reg, scan_next;
  logic [DATA_W-1:0] held_reg, held_next;
  logic [DATA_W-1:0] adc_data_reg, adc_data_next;
  logic [CH_W-1:0]   adc_ch_reg, adc_ch_next;

  logic [CH_W-1:0]   sel_clamped;
  logic [CH_W-1:0]   scan_ch;
  logic              scan_more;

  // Only the top DATA_W bits of a sample ever reach the result, so only those are held.
  logic [DATA_W-1:0] ana_top [CH_NUM];

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      assign ana_top[gi] = anadata[gi*ANA_W + (ANA_W - DATA_W) +: DATA_W];
      if (ANA_W > DATA_W) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^anadata[gi*ANA_W +: (ANA_W - DATA_W)];
      end
    end
  endgenerate

  assign sel_clamped = (ch_sel > CH_LAST) ? CH_LAST : ch_sel;
  assign scan_ch     = cur_ch_reg + CH_W'(1);
  assign scan_more   = scan_reg && (cur_ch_reg < CH_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
      eoc_reg   <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      eoc_reg   <= eoc_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start)               state_next = S_ARMED;
      S_ARMED:   if (!start)              state_next = S_CONVERT;
      S_CONVERT: if (cnt_reg == CNT_LAST) state_next = S_DONE;
      S_DONE:    if (OE)                  state_next = S_READ;
      S_READ:    if (!OE)                 state_next = scan_more ? S_CONVERT : S_IDLE;
      default:                            state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge as the transition.
  always_comb begin
    eoc_next  = 1'b1;
    busy_next = 1'b1;
    case (state_next)
      S_IDLE:    busy_next = 1'b0;
      S_CONVERT: eoc_next  = 1'b0;
      default:   ;
    endcase
  end

  always_comb begin
    cnt_next      = cnt_reg;
    cur_ch_next   = cur_ch_reg;
    scan_next     = scan_reg;
    held_next     = held_reg;
    adc_data_next = adc_data_reg;
    adc_ch_next   = adc_ch_reg;
    case (state_reg)
      S_ARMED: begin
        if (!start) begin
          cur_ch_next = sel_clamped;
          scan_next   = scan_mode;
          held_next   = ana_top[sel_clamped];
          cnt_next    = '0;
        end
      end
      S_CONVERT: begin
        if (cnt_reg != CNT_LAST) cnt_next = cnt_reg + CNT_W'(1);
      end
      S_DONE: begin
        if (OE) begin
          adc_data_next = held_reg;
          adc_ch_next   = cur_ch_reg;
        end
      end
      S_READ: begin
        if (!OE && scan_more) begin
          cur_ch_next = scan_ch;
          held_next   = ana_top[scan_ch];
          cnt_next    = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg      <= '0;
      cur_ch_reg   <= '0;
      scan_reg     <= 1'b0;
      held_reg     <= '0;
      adc_data_reg <= '0;
      adc_ch_reg   <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      cur_ch_reg   <= cur_ch_next;
      scan_reg     <= scan_next;
      held_reg     <= held_next;
      adc_data_reg <= adc_data_next;
      adc_ch_reg   <= adc_ch_next;
    end
  end

`ifdef ADC_MUX_OVR_EN
  logic ovr_reg;

  // A start request while a conversion is in flight wins over the clear on read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovr_reg <= 1'b0;
    end else if (start && (state_reg == S_CONVERT || state_reg == S_DONE || state_reg == S_READ)) begin
      ovr_reg <= 1'b1;
    end else if (state_reg == S_DONE && OE) begin
      ovr_reg <= 1'b0;
    end
  end

  assign ovr = ovr_reg;
`else
  assign ovr = 1'b0;
`endif

  assign EOC      = eoc_reg;
  assign busy     = busy_reg;
  assign adc_data = adc_data_reg;
  assign adc_ch   = adc_ch_reg;

endmodule

// File: tb/tb_adc_mux_ctrl.sv
// Scoreboard bench for adc_mux_ctrl: stimulus pushes expected reads, a negedge monitor pops and compares.
// Second instance covers the 3-channel, 1-cycle configuration.
module tb_adc_mux_ctrl;

  localparam int CH_NUM = 4;
  localparam int ANA_W  = 32;
  localparam int DATA_W = 12;
  localparam int CONV   = 10;
  localparam int CH_W   = 2;
`ifdef ADC_MUX_OVR_EN
  localparam int OVR_EXP = 1;
`else
  localparam int OVR_EXP = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rstn;
  logic [ANA_W-1:0]        ana_w [CH_NUM];
  logic [CH_NUM*ANA_W-1:0] anadata;
  logic                    start, scan_mode, oe;
  logic [CH_W-1:0]         ch_sel;
  logic                    eoc, busy, ovr;
  logic [DATA_W-1:0]       adc_data;
  logic [CH_W-1:0]         adc_ch;

  always_comb begin
    anadata = '0;
    for (int k = 0; k < CH_NUM; k++) anadata[k*ANA_W +: ANA_W] = ana_w[k];
  end

  adc_mux_ctrl #(.CH_NUM(CH_NUM), .ANA_W(ANA_W), .DATA_W(DATA_W), .CONV_CYCLES(CONV)) dut (
    .clk(clk), .rstn(rstn), .anadata(anadata), .start(start), .ch_sel(ch_sel),
    .scan_mode(scan_mode), .OE(oe), .EOC(eoc), .busy(busy), .adc_data(adc_data),
    .adc_ch(adc_ch), .ovr(ovr)
  );

  logic [3*ANA_W-1:0] anadata3;
  logic               start3, scan3, oe3;
  logic [1:0]         ch_sel3;
  logic               eoc3, busy3, ovr3;
  logic [DATA_W-1:0]  data3;
  logic [1:0]         ch3;

  adc_mux_ctrl #(.CH_NUM(3), .ANA_W(ANA_W), .DATA_W(DATA_W), .CONV_CYCLES(1)) dut3 (
    .clk(clk), .rstn(rstn), .anadata(anadata3), .start(start3), .ch_sel(ch_sel3),
    .scan_mode(scan3), .OE(oe3), .EOC(eoc3), .busy(busy3), .adc_data(data3),
    .adc_ch(ch3), .ovr(ovr3)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference: result is the word's top DATA_W bits; out-of-range selects clamp to the last channel.
  function automatic logic [DATA_W-1:0] ref_code(input logic [ANA_W-1:0] w);
    return DATA_W'(w >> (ANA_W - DATA_W));
  endfunction

  function automatic int clamp(input int s, input int n);
    return (s > n - 1) ? n - 1 : s;
  endfunction

  task automatic push_expected(input int sel, input bit scan);
    int   first, last;
    exp_t e;
    first = clamp(sel, CH_NUM);
    last  = scan ? CH_NUM - 1 : first;
    for (int k = first; k <= last; k++) begin
      e.data = ref_code(ana_w[k]);
      e.ch   = CH_W'(k);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: measures each EOC-low run and checks the result after every OE accepted in DONE.
  initial begin
    int   run;
    bit   rd_flag, rd_pending;
    exp_t e;
    run = 0; rd_flag = 0; rd_pending = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        run = 0; rd_flag = 0; rd_pending = 0;
      end else begin
        if (rd_pending) begin
          rd_pending = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_read", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("adc_data", adc_data, e.data);
            check("adc_ch", adc_ch, e.ch);
            $display("read: ch=%0d data=0x%03h (required ch=%0d data=0x%03h)", adc_ch, adc_data, e.ch, e.data);
          end
        end
        if (!eoc) begin
          run++;
          if (run == 1) check("busy_in_convert", busy, 1);
        end else if (run > 0) begin
          check("eoc_low_cycles", run, CONV);
          run = 0;
          rd_flag = 1;
        end
        if (rd_flag && oe) begin
          rd_flag = 0;
          rd_pending = 1;
        end
      end
    end
  end

  // mid: 0 none, 1 change channel 0 mid-conversion, 2 pulse start mid-conversion
  task automatic run_txn(input int sel, input bit scan, input int oe_dly, input bit early_oe,
                         input int mid, input logic [ANA_W-1:0] mid_word);
    int  n;
    bit  seen;
    @(posedge clk); #2;
    start = 1'b1; ch_sel = CH_W'(sel); scan_mode = scan;
    @(posedge clk); @(posedge clk); #2;
    push_expected(sel, scan);
    start = 1'b0;
    n = scan ? CH_NUM - clamp(sel, CH_NUM) : 1;
    for (int i = 0; i < n; i++) begin
      if (i == 0 && mid == 1) begin
        repeat (5) @(posedge clk);
        #2 ana_w[0] = mid_word;
      end
      if (i == 0 && mid == 2) begin
        repeat (3) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        check("ovr_set", ovr, OVR_EXP);
        @(posedge clk); #2;
        check("ovr_held", ovr, OVR_EXP);
      end
      if (early_oe) begin
        @(posedge clk); #2 oe = 1'b1;
      end
      seen = 0;
      for (int t = 0; t < 100; t++) begin
        @(posedge clk); #2;
        if (eoc) begin seen = 1; break; end
      end
      if (!seen) begin
        check("eoc_timeout", 0, 1);
        oe = 1'b0;
        return;
      end
      if (!early_oe) begin
        repeat (oe_dly) @(posedge clk);
        if (oe_dly > 0) #2;
        oe = 1'b1;
      end
      @(posedge clk); #2 oe = 1'b0;
      if (mid == 2 && i == 0) check("ovr_cleared", ovr, 0);
      @(posedge clk); #2;
      if (i == n - 1) check("idle_after_read", busy, 0);
      else            check("scan_eoc_refall", eoc, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; start = 1'b0; scan_mode = 1'b0; oe = 1'b0; ch_sel = '0;
    for (int k = 0; k < CH_NUM; k++) ana_w[k] = '0;
    anadata3 = '0; start3 = 1'b0; scan3 = 1'b0; oe3 = 1'b0; ch_sel3 = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_eoc", eoc, 1);
    check("rst_busy", busy, 0);
    check("rst_adc_data", adc_data, 0);
    check("rst_adc_ch", adc_ch, 0);
    check("rst_ovr", ovr, 0);
    rstn = 1'b1;

    // Single conversion on channel 2
    ana_w[2] = 32'hABC0_0000;
    run_txn(2, 1'b0, 3, 1'b0, 0, '0);

    // Reset five cycles into a conversion, then a clean conversion
    @(posedge clk); #2 start = 1'b1; ch_sel = 2'd1; scan_mode = 1'b0;
    @(posedge clk); #2 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("abort_eoc", eoc, 1);
    check("abort_busy", busy, 0);
    check("abort_adc_data", adc_data, 0);
    exp_q.delete();
    @(posedge clk); #2 rstn = 1'b1;
    ana_w[1] = 32'h5A50_0000;
    run_txn(1, 1'b0, 1, 1'b0, 0, '0);

    // Track-and-hold
    ana_w[0] = 32'h1230_0000;
    run_txn(0, 1'b0, 2, 1'b0, 1, 32'hFFF0_0000);

    // Scan from channel 1
    for (int k = 0; k < CH_NUM; k++) ana_w[k] = $urandom;
    run_txn(1, 1'b1, 1, 1'b0, 0, '0);

    // OE already high when DONE is entered
    ana_w[3] = $urandom;
    run_txn(3, 1'b0, 0, 1'b1, 0, '0);

    // Overrun request mid-conversion
    ana_w[2] = $urandom;
    run_txn(2, 1'b0, 1, 1'b0, 2, '0);

    // Randomised transactions
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < CH_NUM; k++) ana_w[k] = $urandom;
      run_txn($urandom_range(0, CH_NUM - 1), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 0, '0);
    end

    // Three-channel, one-cycle instance with an out-of-range select
    anadata3 = {32'hDEF0_0000, 32'h4560_0000, 32'h7890_0000};
    @(posedge clk); #2 start3 = 1'b1; ch_sel3 = 2'd3;
    @(posedge clk); #2 start3 = 1'b0;
    @(posedge clk); #2;
    check("min_eoc_low", eoc3, 0);
    @(posedge clk); #2;
    check("min_eoc_high", eoc3, 1);
    oe3 = 1'b1;
    @(posedge clk); #2 oe3 = 1'b0;
    check("clamp_adc_ch", ch3, 2);
    check("clamp_adc_data", data3, ref_code(anadata3[2*ANA_W +: ANA_W]));
    $display("read3: ch=%0d data=0x%03h", ch3, data3);
    @(posedge clk); #2;
    check("clamp_idle", busy3, 0);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
